// File: rtl/log2_normalizer.sv
// Leading-one normalizer for the fixed-point log2 path: splits an unsigned sample into
// integer part (leading-one position) and a table index. Optional LOG2_NORM_ROUND_EN adds guard-bit rounding.
module log2_normalizer #(
    parameter int IN_W  = 16,
    parameter int IDX_W = 5,
    parameter int EXP_W = 4
) (
    input  logic             i_CLK,
    input  logic             reset,
    input  logic             enb,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] out_exp,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_zero
);

`ifdef LOG2_NORM_ROUND_EN
    localparam int GRD_W = 1;
`else
    localparam int GRD_W = 0;
`endif
    // Window of IDX_W (+guard) bits taken just below the leading one.
    localparam int WIN_W = IDX_W + GRD_W;
    localparam int EXT_W = IN_W - 1 + WIN_W;

    logic             v1_q, v2_q;
    logic [IN_W-2:0]  data1_q;
    logic             zero1_q;
    logic [EXP_W-1:0] p1_q, p_d;
    logic [EXP_W-1:0] exp_q;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             zero_q;
    logic             adv1, adv2;
    logic [EXT_W-1:0] ext;
    logic [WIN_W-1:0] win;

    assign adv2      = ~v2_q | out_ready;
    assign adv1      = ~v1_q | adv2;
    assign in_ready  = enb & adv1;
    assign out_valid = v2_q;
    assign out_exp   = exp_q;
    assign out_idx   = idx_q;
    assign out_zero  = zero_q;

    always_comb begin
        p_d = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (in_data[i]) p_d = EXP_W'(i);
        end
    end

    // The leading one itself is implied by p, so only the bits below the MSB are kept.
    assign ext = {data1_q, {WIN_W{1'b0}}};

    always_comb begin
        win = '0;
        for (int k = 0; k < IN_W; k++) begin
            if (p1_q == EXP_W'(k)) win = ext[k +: WIN_W];
        end
    end

`ifdef LOG2_NORM_ROUND_EN
    logic [IDX_W:0] sum;
    always_comb begin
        sum   = {1'b0, win[WIN_W-1:1]} + {{IDX_W{1'b0}}, win[0]};
        idx_d = sum[IDX_W] ? {IDX_W{1'b1}} : sum[IDX_W-1:0];
        if (zero1_q) idx_d = '0;
    end
`else
    always_comb begin
        idx_d = win;
        if (zero1_q) idx_d = '0;
    end
`endif

    always_ff @(posedge i_CLK) begin
        if (reset) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            data1_q <= '0;
            zero1_q <= 1'b0;
            p1_q    <= '0;
            exp_q   <= '0;
            idx_q   <= '0;
            zero_q  <= 1'b0;
        end else if (enb) begin
            if (adv1) begin
                v1_q    <= in_valid;
                data1_q <= in_data[IN_W-2:0];
                zero1_q <= (in_data == '0);
                p1_q    <= p_d;
            end
            if (adv2) begin
                v2_q   <= v1_q;
                exp_q  <= zero1_q ? '0 : p1_q;
                idx_q  <= idx_d;
                zero_q <= zero1_q;
            end
        end
    end

endmodule

// File: tb/tb_log2_normalizer.sv
// Scoreboard bench for log2_normalizer: driver pushes hand-computed expectations,
// a negedge monitor pops and compares on every output transfer.
module tb_log2_normalizer;

    logic        clk = 1'b0;
    logic        reset, enb, in_valid, out_ready;
    logic [15:0] in_data;
    logic        in_ready, out_valid, out_zero;
    logic [3:0]  out_exp;
    logic [4:0]  out_idx;

    int checks = 0;
    int failures = 0;
    int n_acc = 0;
    logic [9:0] sb[$];

    log2_normalizer #(.IN_W(16), .IDX_W(5), .EXP_W(4)) dut (
        .i_CLK(clk), .reset(reset), .enb(enb), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_exp(out_exp), .out_idx(out_idx), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] pk(input logic z, input int e, input int i);
        return {z, 4'(e), 5'(i)};
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic send_one(input logic [15:0] d, input logic [9:0] e);
        bit ok = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                n_acc++;
                ok = 1;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: data %0h not accepted", d);
        end
    endtask

    // Monitor: compares on each output transfer and checks outputs hold while frozen.
    logic       prev_hold = 1'b0;
    logic [10:0] prev_out;
    always @(negedge clk) begin
        logic [9:0] e;
        if (prev_hold && !reset)
            chk("hold", {5'd0, out_valid, out_zero, out_exp, out_idx}, {5'd0, prev_out});
        if (!reset && enb && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out: got %0h want none", {out_zero, out_exp, out_idx});
            end else begin
                e = sb.pop_front();
                chk("out", {6'd0, out_zero, out_exp, out_idx}, {6'd0, e});
            end
        end
        prev_hold = !reset && (!enb || (out_valid && !out_ready));
        prev_out  = {out_valid, out_zero, out_exp, out_idx};
    end

    logic [15:0] dv[14];
    logic [9:0]  de[14];
    logic [15:0] s2v[8];
    logic [9:0]  s2e[8];

    initial begin
        dv[0]  = 16'h0001; de[0]  = pk(0, 0, 0);
        dv[1]  = 16'h00B4; de[1]  = pk(0, 7, 13);
        dv[2]  = 16'h0003; de[2]  = pk(0, 1, 16);
`ifdef LOG2_NORM_ROUND_EN
        dv[3]  = 16'h0065; de[3]  = pk(0, 6, 19);
        dv[4]  = 16'h005B; de[4]  = pk(0, 6, 14);
`else
        dv[3]  = 16'h0065; de[3]  = pk(0, 6, 18);
        dv[4]  = 16'h005B; de[4]  = pk(0, 6, 13);
`endif
        dv[5]  = 16'hFFFF; de[5]  = pk(0, 15, 31);
        dv[6]  = 16'h0000; de[6]  = pk(1, 0, 0);
        dv[7]  = 16'h8000; de[7]  = pk(0, 15, 0);
        dv[8]  = 16'h1234; de[8]  = pk(0, 12, 4);
        dv[9]  = 16'h00FF; de[9]  = pk(0, 7, 31);
        dv[10] = 16'h002D; de[10] = pk(0, 5, 13);
        dv[11] = 16'h0005; de[11] = pk(0, 2, 8);
        dv[12] = 16'h0000; de[12] = pk(1, 0, 0);
        dv[13] = 16'h0007; de[13] = pk(0, 2, 24);

        s2v[0] = 16'h0100; s2e[0] = pk(0, 8, 0);
        s2v[1] = 16'h0180; s2e[1] = pk(0, 8, 16);
        s2v[2] = 16'h01F0; s2e[2] = pk(0, 8, 30);
        s2v[3] = 16'h0333; s2e[3] = pk(0, 9, 19);
        s2v[4] = 16'h4000; s2e[4] = pk(0, 14, 0);
        s2v[5] = 16'h7FFF; s2e[5] = pk(0, 14, 31);
        s2v[6] = 16'h0200; s2e[6] = pk(0, 9, 0);
        s2v[7] = 16'h0201; s2e[7] = pk(0, 9, 0);

        reset = 1'b1; enb = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out", {11'd0, out_valid, out_zero, out_exp != 0, out_idx != 0, in_ready}, 16'h0001);
        @(posedge clk); #1;
        reset = 1'b0;

        // Latency: out_valid appears exactly two cycles after the accepting cycle.
        send_one(16'h0001, pk(0, 0, 0));
        in_valid = 1'b0;
        @(negedge clk); chk("lat_c1", {15'd0, out_valid}, 16'd0);
        @(negedge clk); chk("lat_c2", {15'd0, out_valid}, 16'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) send_one(dv[i], de[i]);
        in_valid = 1'b0;
        repeat (4) @(posedge clk); #1;

        // Stream 1..8 with a 3-cycle output stall after the third accept.
        n_acc = 0;
        fork
            begin
                for (int i = 1; i <= 8; i++) begin
                    case (i)
                        1: send_one(16'(i), pk(0, 0, 0));
                        2: send_one(16'(i), pk(0, 1, 0));
                        3: send_one(16'(i), pk(0, 1, 16));
                        4: send_one(16'(i), pk(0, 2, 0));
                        5: send_one(16'(i), pk(0, 2, 8));
                        6: send_one(16'(i), pk(0, 2, 16));
                        7: send_one(16'(i), pk(0, 2, 24));
                        default: send_one(16'(i), pk(0, 3, 0));
                    endcase
                end
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 100 && n_acc < 3; c++) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready", {15'd0, in_ready}, 16'd0);
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk); #1;

        // Stream with enb low for 2 cycles mid-stream.
        n_acc = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) send_one(s2v[i], s2e[i]);
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 100 && n_acc < 4; c++) @(posedge clk);
                #1 enb = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    chk("enb_in_ready", {15'd0, in_ready}, 16'd0);
                end
                @(posedge clk); #1 enb = 1'b1;
            end
        join
        repeat (4) @(posedge clk); #1;

        // Reset with both stages full discards them.
        out_ready = 1'b0;
        send_one(16'h0003, pk(0, 1, 16));
        send_one(16'h0005, pk(0, 2, 8));
        in_valid = 1'b0;
        @(negedge clk); chk("full_in_ready", {15'd0, in_ready}, 16'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_reset", {11'd0, out_valid, out_zero, out_exp != 0, out_idx != 0, in_ready}, {15'd0, enb});
        @(posedge clk); #1;
        send_one(16'h00B4, pk(0, 7, 13));
        in_valid = 1'b0;
        @(negedge clk); chk("rst_lat_c1", {15'd0, out_valid}, 16'd0);
        @(negedge clk); chk("rst_lat_c2", {15'd0, out_valid}, 16'd1);

        for (int c = 0; c < 50 && sb.size() != 0; c++) @(posedge clk);
        @(negedge clk);
        chk("drain", 16'(sb.size()), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
